// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - display-data and pin bundle between score logic and the scan driver
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp;
    logic                      lz_blank;
    logic [NUM_DIGITS-1:0]     blink_en;
    logic                      msg_en;
    logic [8*NUM_DIGITS-1:0]   msg_seg;
    logic [NUM_DIGITS-1:0]     AN;
    logic [7:0]                seg;
    logic                      frame_done;

    modport master (
        output enable, digits, dp, lz_blank, blink_en, msg_en, msg_seg,
        input  AN, seg, frame_done
    );

    modport slave (
        input  enable, digits, dp, lz_blank, blink_en, msg_en, msg_seg,
        output AN, seg, frame_done
    );
endinterface

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed seven-segment scan driver with blink, dp and zero blanking
module seg_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 50,
    parameter bit HEX_EN       = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;
    logic                  frame_phase;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            seg_q;
    logic                  frame_done_q;

    logic                  tick;
    logic [IW-1:0]         slot;
    logic [3:0]            slot_value;
    logic                  lead_zero;
    logic                  lz_hit;
    logic                  phase_now;
    logic [NUM_DIGITS-1:0] an_on;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [7:0]            seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        if (!HEX_EN && v > 4'd9)
            s = 7'h7F;
        return s;
    endfunction

    always_comb begin
        tick       = (presc == PRESC_MAX);
        slot       = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        slot_value = bus.digits[4*slot +: 4];

        lead_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k <= int'(slot) && bus.digits[4*k +: 4] != 4'd0)
                lead_zero = 1'b0;
        end
        lz_hit = bus.lz_blank && (slot != IDX_MAX) && lead_zero;

        // Slot 0 opens a frame with the live phase; the rest of the frame keeps the phase latched there.
        phase_now = (slot == '0) ? blink_phase : frame_phase;

        an_on = '1;
        an_on[NUM_DIGITS-1-int'(slot)] = 1'b0;

        an_nxt  = '1;
        seg_nxt = 8'hFF;
        if (!bus.enable) begin
            an_nxt  = '1;
            seg_nxt = 8'hFF;
        end else if (bus.msg_en) begin
            an_nxt  = an_on;
            seg_nxt = bus.msg_seg[8*slot +: 8];
        end else if (phase_now && bus.blink_en[slot]) begin
            an_nxt  = '1;
            seg_nxt = 8'hFF;
        end else if (lz_hit) begin
            an_nxt  = an_on;
            seg_nxt = {~bus.dp[slot], 7'h7F};
        end else begin
            an_nxt  = an_on;
            seg_nxt = {~bus.dp[slot], decode(slot_value)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            idx          <= IDX_MAX;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            frame_phase  <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            presc        <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx   <= slot;
                an_q  <= an_nxt;
                seg_q <= seg_nxt;
                if (slot == '0) begin
                    frame_done_q <= 1'b1;
                    frame_phase  <= blink_phase;
                    if (blink_cnt == BLINK_MAX) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.AN         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
endmodule
